// File: rtl/freq_pkg.sv
// ============================================================================
// freq_pkg : shared constants and FSM state type for the gated frequency counter
// Revision : 1.0
// ============================================================================
`default_nettype none

package freq_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int GATE_1S_100MHZ = 100_000_000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } gate_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
// sync_edge_det : 2-FF synchroniser followed by a rising-edge detector
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    // prev resets low so an input already high at reset release yields one edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= d;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign rise = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/freq_gate_counter.sv
// ============================================================================
// freq_gate_counter : counts sig_in rising edges over back-to-back windows of
//                     GATE_CYCLES clocks. Build option FREQ_SAT_EN saturates
//                     the edge count instead of wrapping.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_1S_100MHZ,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             ovf
);

    localparam int              GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);

    gate_state_t         r_state;
    gate_state_t         w_next_state;
    logic [GATE_W-1:0]   r_gate_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic                r_win_ovf;
    logic                w_rise;
    logic [CNT_W:0]      w_sum;
    logic                w_carry;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_terminal;

    sync_edge_det u_sync_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .rise (w_rise)
    );

    assign w_sum      = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_rise};
    assign w_carry    = w_sum[CNT_W];
    assign w_terminal = (r_state == COUNT) && (r_gate_cnt == c_gate_last);

`ifdef FREQ_SAT_EN
    assign w_cnt_next = w_carry ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
`else
    assign w_cnt_next = w_sum[CNT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping en on the terminal cycle still lets the datapath publish
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (en)  w_next_state = COUNT;
            COUNT:   if (!en) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (w_terminal) begin
                // terminal-cycle edge belongs to the closing window
                freq       <= w_cnt_next;
                ovf        <= r_win_ovf | w_carry;
                freq_valid <= 1'b1;
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_win_ovf  <= 1'b0;
            end else if ((r_state == COUNT) && en) begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_cnt_next;
                r_win_ovf  <= r_win_ovf | w_carry;
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_win_ovf  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
// ============================================================================
// tb_freq_gate_counter : directed scoreboard bench for freq_gate_counter
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_freq_gate_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       sig_in;
    logic [7:0] freq_a;
    logic       valid_a, ovf_a;
    logic [3:0] freq_b;
    logic       valid_b, ovf_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   period = 0;
    logic wave = 1'b0;
    logic use_man = 1'b0;
    logic man_sig = 1'b0;

    typedef struct {
        logic [7:0] f;
        logic       o;
        int         c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    assign sig_in = use_man ? man_sig : wave;

    freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .sig_in(sig_in),
        .freq(freq_a), .freq_valid(valid_a), .ovf(ovf_a)
    );

    freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_in),
        .freq(freq_b), .freq_valid(valid_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // square wave: high for period/2 cycles of every period
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            if (period < 2) begin
                wave  = 1'b0;
                phase = 0;
            end else begin
                phase = (phase + 1) % period;
                wave  = (phase < period / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitors: pop one expectation per freq_valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_a === 1'b1) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected_valid: got freq=%0d expected no pulse (cycle %0d)", freq_a, cyc);
                end else begin
                    e = qa.pop_front();
                    check("a_freq", {24'd0, freq_a}, {24'd0, e.f});
                    check("a_ovf", {31'd0, ovf_a}, {31'd0, e.o});
                    check("a_cycle", cyc, e.c);
                end
            end
            if (valid_b === 1'b1) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_valid: got freq=%0d expected no pulse (cycle %0d)", freq_b, cyc);
                end else begin
                    e = qb.pop_front();
                    check("b_freq", {28'd0, freq_b}, {24'd0, e.f});
                    check("b_ovf", {31'd0, ovf_b}, {31'd0, e.o});
                    check("b_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input bit sel, input int f, input bit o, input int c);
        exp_t e;
        e.f = 8'(f);
        e.o = o;
        e.c = c;
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    // n back-to-back windows with a steady wave, en dropped right after the last publish
    task automatic run_windows(input bit sel, input int per, input int n, input int fexp, input bit oexp);
        int c;
        period  = per;
        use_man = 1'b0;
        repeat (20) @(negedge clk);
        c = cyc;
        if (sel) en_b = 1'b1;
        else     en_a = 1'b1;
        for (int k = 1; k <= n; k++) push(sel, fexp, oexp, c + 1 + 100 * k);
        wait_cyc(c + 1 + 100 * n);
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int c;
        int r;
        int exp5;
`ifdef FREQ_SAT_EN
        exp5 = 15;
`else
        exp5 = 9;
`endif
        repeat (3) @(negedge clk);
        check("reset_freq", {24'd0, freq_a}, 32'd0);
        check("reset_valid", {31'd0, valid_a}, 32'd0);
        check("reset_ovf", {31'd0, ovf_a}, 32'd0);
        rst = 1'b0;

        run_windows(1'b0, 10, 3, 10, 1'b0);
        run_windows(1'b0, 0, 2, 0, 1'b0);
        run_windows(1'b0, 4, 2, 25, 1'b0);

        // three mid-window pulses plus one landing on the terminal cycle
        period  = 0;
        use_man = 1'b1;
        man_sig = 1'b0;
        repeat (5) @(negedge clk);
        c = cyc;
        en_a = 1'b1;
        push(1'b0, 4, 1'b0, c + 101);
        push(1'b0, 0, 1'b0, c + 201);
        for (int k = 0; k <= 200; k++) begin
            wait_cyc(c + k);
            man_sig = ((k >= 10 && k < 12) || (k >= 30 && k < 32) ||
                       (k >= 50 && k < 52) || (k >= 98 && k < 100));
        end
        wait_cyc(c + 201);
        en_a = 1'b0;
        repeat (5) @(negedge clk);

        // abort at gate_cnt = 50, then restart
        period  = 10;
        use_man = 1'b0;
        repeat (20) @(negedge clk);
        c = cyc;
        en_a = 1'b1;
        push(1'b0, 10, 1'b0, c + 101);
        wait_cyc(c + 151);
        en_a = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_hold_freq", {24'd0, freq_a}, 32'd10);
        check("abort_hold_ovf", {31'd0, ovf_a}, 32'd0);
        c = cyc;
        en_a = 1'b1;
        push(1'b0, 10, 1'b0, c + 101);
        wait_cyc(c + 101);
        en_a = 1'b0;
        repeat (5) @(negedge clk);

        run_windows(1'b1, 4, 1, exp5, 1'b1);
        run_windows(1'b1, 0, 1, 0, 1'b0);

        // reset at gate_cnt = 70 with sig_in high across the release
        period = 10;
        repeat (20) @(negedge clk);
        c = cyc;
        en_a = 1'b1;
        wait_cyc(c + 71);
        rst = 1'b1;
        #1;
        check("midrst_freq", {24'd0, freq_a}, 32'd0);
        check("midrst_valid", {31'd0, valid_a}, 32'd0);
        check("midrst_ovf", {31'd0, ovf_a}, 32'd0);
        use_man = 1'b1;
        man_sig = 1'b1;
        period  = 0;
        repeat (3) @(negedge clk);
        r = cyc;
        rst = 1'b0;
        push(1'b0, 1, 1'b0, r + 101);
        wait_cyc(r + 101);
        en_a = 1'b0;
        repeat (10) @(negedge clk);

        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
